instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit_next_pc_calc.sv | 31 +++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage constants: FSM encoding, opcode field position, PC step.
// The control decoder uses the same values, so change them in both places together.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam int          OP_MSB = 31;
  localparam int          OP_LSB = 26;
  localparam logic [31:0] PC_INC = 32'd4;

  // Word offset from a 16-bit immediate: sign-extend, then scale by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC: jump beats taken branch, which beats sequential.
// All adds are 32-bit and drop the carry, so the PC wraps.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic        unused_op_bits;

  // The opcode field is consumed by the decoder and plays no part in the target.
  assign unused_op_bits = ^inst[OP_MSB:OP_LSB];

  always_comb begin
    pc4 = pc + PC_INC;
    if (jump) begin
      next_pc = {pc4[31:28], inst[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + branch_offset(inst[15:0]);
    end else begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue stage: holds PC, fetches over a ready handshake, presents IR until acked.
// Latency: 2 cycles per instruction with zero-wait memory and immediate ack.
// Backpressure: waits in FETCH for imem_ready and in ISSUE for inst_ack. FETCH_PERF_CNT_EN adds counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic        inst_valid,
  input  logic        inst_ack,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc_calc (
    .pc      (pc_q),
    .inst    (inst_q),
    .branch  (branch),
    .jump    (jump),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // IDLE only exists to give one dead cycle after reset release.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (inst_ack) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == ISSUE);
  assign inst       = inst_q;
  assign op         = inst_q[OP_MSB:OP_LSB];
  assign pc         = pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (state_q == ISSUE && inst_ack) begin
      retired_d = retired_q + 32'd1;
    end
    if ((state_q == FETCH && !imem_ready) || (state_q == ISSUE && !inst_ack)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level PC/IR model.
// Reset PC sits just below the top of memory so the first fetches exercise the wrap.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [5:0]  op;
  logic        inst_valid;
  logic        inst_ack = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .op         (op),
    .inst_valid (inst_valid),
    .inst_ack   (inst_ack),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .pc         (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: what the stage should be showing right now.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_valid;
  bit          m_req;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_retired;
  logic [31:0] m_stall;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input bit br, input bit jp, input bit z);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && z) begin
      off = $signed(w[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic model_reset();
    m_pc    = RST_PC;
    m_inst  = '0;
    m_valid = 0;
    m_req   = 0;
`ifdef FETCH_PERF_CNT_EN
    m_retired = '0;
    m_stall   = '0;
`endif
  endtask

  task automatic check_outputs();
    chk("imem_req",   imem_req,   m_req);
    chk("inst_valid", inst_valid, m_valid);
    chk("pc",         pc,         m_pc);
    chk("imem_addr",  imem_addr,  m_pc);
    chk("inst",       inst,       m_inst);
    chk("op",         op,         m_inst[31:26]);
`ifdef FETCH_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, m_retired);
    chk("stall_cnt",   stall_cnt,   m_stall);
`endif
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input bit rdy, input bit ack, input bit br, input bit jp, input bit z,
                      input logic [31:0] word);
    imem_ready = rdy;
    imem_rdata = word;
    inst_ack   = ack;
    branch     = br;
    jump       = jp;
    zero       = z;
    @(posedge clk);
`ifdef FETCH_PERF_CNT_EN
    if (m_req && !rdy) m_stall = m_stall + 32'd1;
    if (m_valid && !ack) m_stall = m_stall + 32'd1;
    if (m_valid && ack) m_retired = m_retired + 32'd1;
`endif
    if (m_req) begin
      if (rdy) begin
        m_inst  = word;
        m_valid = 1;
        m_req   = 0;
      end
    end else if (m_valid) begin
      if (ack) begin
        m_pc    = ref_next(m_pc, m_inst, br, jp, z);
        m_valid = 0;
        m_req   = 1;
      end
    end else begin
      m_req = 1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Full fetch+issue; inputs the DUT must ignore are filled with random junk.
  task automatic fetch_issue(input logic [31:0] word, input bit br, input bit jp, input bit z,
                             input int waits, input int stalls);
    for (int i = 0; i < waits; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), word);
    for (int i = 0; i < stalls; i++)
      step(1'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    step(1'($urandom), 1, br, jp, z, $urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0, 32'hDEAD_BEEF);  // dead cycle: ready must be ignored

    // Sequential flow across the top of memory: F8, FC, 0, 4, 8, C.
    repeat (6) fetch_issue(32'h0000_0020, 0, 0, 0, 0, 0);
    // Wait states at 0x10.
    fetch_issue(32'h0000_0020, 0, 0, 0, 3, 0);
    // Jump to 0x100, then forward / backward / not-taken branches.
    fetch_issue(32'h0800_0040, 0, 1, 0, 0, 0);
    fetch_issue(32'h1000_0003, 1, 0, 1, 0, 0);
    fetch_issue(32'h1000_FFFF, 1, 0, 1, 0, 0);
    fetch_issue(32'h1000_FFFF, 1, 0, 0, 0, 0);
    // Jump wins over a taken branch.
    fetch_issue(32'h0800_0040, 1, 1, 1, 0, 0);
    // Long issue stall.
    fetch_issue($urandom, 0, 0, 0, 0, 5);

    for (int n = 0; n < 300; n++) begin
      fetch_issue($urandom, ($urandom % 3) == 0, ($urandom % 8) == 0, 1'($urandom),
                  $urandom % 4, $urandom % 4);
    end

    // Asynchronous reset in the middle of ISSUE, with a stray ready while held.
    step(1, 0, 0, 0, 0, 32'h0000_0020);
    step(1, 0, 0, 0, 0, 32'h0000_0020);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0, 32'h1234_5678);
    repeat (4) fetch_issue($urandom, 1'($urandom), 0, 1'($urandom), $urandom % 3, $urandom % 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
